// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states and the packed stage-control word.
package pipe_hazard_ctrl_pkg;

   localparam int REGIDX_DEF = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   // A flush bit only acts when the matching enable is also 1: the register loads a NOP/zero.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic memwb_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE  = ctrl_t'(9'b00000_0000);
   localparam ctrl_t CTRL_NORM  = ctrl_t'(9'b11111_0000);
   localparam ctrl_t CTRL_REDIR = ctrl_t'(9'b11111_1100);
   localparam ctrl_t CTRL_LU    = ctrl_t'(9'b00111_0100);
   localparam ctrl_t CTRL_MS    = ctrl_t'(9'b00001_0001);

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID instruction's sources and the load in EX.
// Purely combinational; x0 is never a hazard since it is hardwired to zero.
module hazard_detect
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REGIDX = REGIDX_DEF
) (
   input  logic [REGIDX-1:0] id_rs1,
   input  logic [REGIDX-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REGIDX-1:0] ex_rd,
   input  logic              ex_memread,
   output logic              lu
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
   assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
   assign lu      = ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RUN / MEM_WAIT / FAULT FSM with memory-wait timeout.
// Optional perf counters (stall_cnt, flush_cnt) are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REGIDX   = REGIDX_DEF,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REGIDX-1:0] id_rs1,
   input  logic [REGIDX-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REGIDX-1:0] ex_rd,
   input  logic              ex_memread,
   input  logic              ex_redirect,
   input  logic              mem_access,
   input  logic              dmem_ready,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              idex_en,
   output logic              exmem_en,
   output logic              memwb_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic              memwb_flush,
   output logic              mem_timeout,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   state_t         state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_d;
   ctrl_t          ctrl, ctrl_o;
   logic           lu;
   logic           ms;

   hazard_detect #(.REGIDX(REGIDX)) u_hazard_detect (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .ex_rd      (ex_rd),
      .ex_memread (ex_memread),
      .lu         (lu)
   );

   assign ms = mem_access && !dmem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_d;
      end
   end

   // Hazard inputs are held by the frozen stage registers, so a redirect or
   // load-use masked by a memory stall is simply seen again on the release cycle.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_cnt_q;
      ctrl    = CTRL_IDLE;
      case (state_q)
         RUN, MEM_WAIT: begin
            if (ms) begin
               ctrl = CTRL_MS;
               if (state_q == RUN) begin
                  state_d = MEM_WAIT;
                  wait_d  = WCW'(1);
               end else if (wait_cnt_q == WCW'(MAX_WAIT)) begin
                  state_d = FAULT;
               end else begin
                  wait_d = wait_cnt_q + WCW'(1);
               end
            end else begin
               state_d = RUN;
               wait_d  = '0;
               if (ex_redirect)
                  ctrl = CTRL_REDIR;
               else if (lu)
                  ctrl = CTRL_LU;
               else
                  ctrl = CTRL_NORM;
            end
         end
         default: state_d = FAULT;
      endcase
   end

   // Outputs drop to their idle values the instant rst rises, not at the next edge.
   assign ctrl_o      = rst ? CTRL_IDLE : ctrl;
   assign pc_en       = ctrl_o.pc_en;
   assign ifid_en     = ctrl_o.ifid_en;
   assign idex_en     = ctrl_o.idex_en;
   assign exmem_en    = ctrl_o.exmem_en;
   assign memwb_en    = ctrl_o.memwb_en;
   assign ifid_flush  = ctrl_o.ifid_flush;
   assign idex_flush  = ctrl_o.idex_flush;
   assign exmem_flush = ctrl_o.exmem_flush;
   assign memwb_flush = ctrl_o.memwb_flush;
   assign mem_timeout = !rst && (state_q == FAULT);

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;
   logic        stall_inc;
   logic        flush_inc;

   // Only a redirect drives ifid_flush, so it marks an applied redirect.
   assign stall_inc = !ctrl_o.pc_en && (state_q != FAULT) && !rst;
   assign flush_inc = ctrl_o.ifid_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_inc && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
         if (flush_inc && (flush_q != 32'hFFFF_FFFF))
            flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, redirect, memory wait, timeout fault and async reset.
module tb_pipe_hazard_ctrl;

   localparam int REGIDX   = 5;
   localparam int MAX_WAIT = 4;

   localparam logic [8:0] E_ZERO  = 9'b00000_0000;
   localparam logic [8:0] E_NORM  = 9'b11111_0000;
   localparam logic [8:0] E_REDIR = 9'b11111_1100;
   localparam logic [8:0] E_LU    = 9'b00111_0100;
   localparam logic [8:0] E_MS    = 9'b00001_0001;

   logic              clk = 1'b0;
   logic              rst;
   logic [REGIDX-1:0] id_rs1, id_rs2, ex_rd;
   logic              id_use_rs1, id_use_rs2, ex_memread, ex_redirect;
   logic              mem_access, dmem_ready;
   logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic              ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic              mem_timeout;
   logic [31:0]       stall_cnt, flush_cnt;
   logic [8:0]        ctl;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REGIDX(REGIDX), .MAX_WAIT(MAX_WAIT)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rd       (ex_rd),
      .ex_memread  (ex_memread),
      .ex_redirect (ex_redirect),
      .mem_access  (mem_access),
      .dmem_ready  (dmem_ready),
      .pc_en       (pc_en),
      .ifid_en     (ifid_en),
      .idex_en     (idex_en),
      .exmem_en    (exmem_en),
      .memwb_en    (memwb_en),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .exmem_flush (exmem_flush),
      .memwb_flush (memwb_flush),
      .mem_timeout (mem_timeout),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_in();
      id_rs1      = '0;
      id_rs2      = '0;
      id_use_rs1  = 1'b0;
      id_use_rs2  = 1'b0;
      ex_rd       = '0;
      ex_memread  = 1'b0;
      ex_redirect = 1'b0;
      mem_access  = 1'b0;
      dmem_ready  = 1'b1;
   endtask

   task automatic chk_cnt(input string tag, input int exp_stall, input int exp_flush);
`ifdef PIPE_PERF_CNT_EN
      chk({tag, "_stall_cnt"}, stall_cnt, 32'(exp_stall));
      chk({tag, "_flush_cnt"}, flush_cnt, 32'(exp_flush));
`else
      chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
      chk({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      clear_in();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ctl", 32'(ctl), 32'(E_ZERO));
      chk("rst_timeout", 32'(mem_timeout), 32'd0);
      chk_cnt("rst", 0, 0);

      // Load-use on rs1, then the bubble lets the load move to MEM
      @(negedge clk);
      rst = 1'b0;
      ex_rd = 5'd5; ex_memread = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      #1 chk("lu_rs1", 32'(ctl), 32'(E_LU));
      @(negedge clk);
      ex_rd = '0; ex_memread = 1'b0;
      #1 chk("lu_after", 32'(ctl), 32'(E_NORM));

      // No hazard: x0 destination, or the source is not read
      @(negedge clk);
      ex_rd = '0; ex_memread = 1'b1; id_rs1 = '0; id_use_rs1 = 1'b1;
      #1 chk("lu_x0", 32'(ctl), 32'(E_NORM));
      @(negedge clk);
      ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; id_use_rs2 = 1'b1; id_rs2 = 5'd6;
      #1 chk("lu_unused", 32'(ctl), 32'(E_NORM));
      @(negedge clk);
      id_rs2 = 5'd5;
      #1 chk("lu_rs2", 32'(ctl), 32'(E_LU));

      // Redirect wins over a simultaneous load-use
      @(negedge clk);
      ex_redirect = 1'b1;
      #1 chk("redir_lu", 32'(ctl), 32'(E_REDIR));
      @(negedge clk);
      clear_in();
      #1 chk("redir_after", 32'(ctl), 32'(E_NORM));
      chk_cnt("phase1", 2, 1);

      rst = 1'b1;
      #1 chk("rst_pulse_ctl", 32'(ctl), 32'(E_ZERO));
      chk_cnt("rst_pulse", 0, 0);

      // Three wait cycles, a redirect during the wait is ignored, then release
      @(negedge clk);
      rst = 1'b0;
      mem_access = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ex_redirect = (i == 1);
         #1 chk($sformatf("ms_wait%0d", i), 32'(ctl), 32'(E_MS));
         @(negedge clk);
      end
      ex_redirect = 1'b0; dmem_ready = 1'b1;
      #1 chk("ms_release", 32'(ctl), 32'(E_NORM));
      @(negedge clk);
      mem_access = 1'b0;
      #1 chk("ms_run", 32'(ctl), 32'(E_NORM));
      chk_cnt("ms", 3, 0);

      // Reset asserted in the middle of MEM_WAIT acts immediately
      @(negedge clk);
      mem_access = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      #1 chk("mw_pre_rst", 32'(ctl), 32'(E_MS));
      rst = 1'b1;
      #1 chk("mw_rst_ctl", 32'(ctl), 32'(E_ZERO));
      chk_cnt("mw_rst", 0, 0);
      @(negedge clk);
      rst = 1'b0;
      clear_in();
      #1 chk("mw_rst_run", 32'(ctl), 32'(E_NORM));

      // Held wait: FAULT five edges after the stall starts
      @(negedge clk);
      mem_access = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1 chk($sformatf("to_wait%0d", i), 32'(ctl), 32'(E_MS));
         chk($sformatf("to_flag%0d", i), 32'(mem_timeout), 32'd0);
         @(negedge clk);
      end
      #1 chk("fault_ctl", 32'(ctl), 32'(E_ZERO));
      chk("fault_flag", 32'(mem_timeout), 32'd1);
      @(negedge clk);
      clear_in();
      ex_redirect = 1'b1;
      #1 chk("fault_sticky", 32'(ctl), 32'(E_ZERO));
      chk("fault_sticky_flag", 32'(mem_timeout), 32'd1);
      @(negedge clk);
      ex_redirect = 1'b0;
      #1 chk_cnt("fault", 5, 0);
      rst = 1'b1;
      #1 chk("fault_rst_flag", 32'(mem_timeout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("fault_rst_ctl", 32'(ctl), 32'(E_NORM));
      chk("fault_rst_flag2", 32'(mem_timeout), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
